// File: rtl/fb_load_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_defines (package)
// Brief    : Shared widths, depth default and register-zero constant.
// Revision : 1.0
// ============================================================================
package fb_defines;
  localparam int unsigned c_RADDR_W = 5;
  localparam int unsigned c_DEPTH   = 4;
  localparam int unsigned c_CNT_W   = 32;
  localparam logic [c_RADDR_W-1:0] c_REG_ZERO = '0;
endpackage
`default_nettype wire

// File: rtl/fb_rd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fb_rd_fifo
// Brief    : In-order destination-register FIFO of loads past EX, exposing
//            every entry and the head index for a parallel compare.
// Revision : 1.0
// ============================================================================
module fb_rd_fifo
  import fb_defines::*;
#(
  parameter int unsigned RADDR_W = c_RADDR_W,
  parameter int unsigned DEPTH   = c_DEPTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_push,
  input  logic                              i_pop,
  input  logic [RADDR_W-1:0]                i_wr_rd,
  output logic [DEPTH-1:0][RADDR_W-1:0]     o_rd,
  output logic [DEPTH-1:0]                  o_valid,
  output logic [$clog2(DEPTH)-1:0]          o_head,
  output logic [$clog2(DEPTH):0]            o_count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][RADDR_W-1:0] r_rd;
  logic [DEPTH-1:0]              r_valid;
  logic [PTR_W-1:0]              r_head;
  logic [PTR_W-1:0]              r_tail;
  logic [PTR_W:0]                r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd    <= '0;
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // Pop is written before push so that on a full FIFO, where head and
      // tail coincide, the newly pushed entry keeps its valid bit.
      if (i_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (i_push) begin
        r_rd[r_tail]    <= i_wr_rd;
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      if (i_push && !i_pop) begin
        r_count <= r_count + (PTR_W+1)'(1);
      end else if (!i_push && i_pop) begin
        r_count <= r_count - (PTR_W+1)'(1);
      end
    end
  end

  assign o_rd    = r_rd;
  assign o_valid = r_valid;
  assign o_head  = r_head;
  assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/fb_load_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : fb_load_scoreboard
// Brief    : Load-use hazard unit: EX-stage load compare plus scoreboard of
//            in-flight loads; drives lock/ex_hold and counts stall cycles.
// Revision : 1.0
// ============================================================================
module fb_load_scoreboard
  import fb_defines::*;
#(
  parameter int unsigned RADDR_W = c_RADDR_W,
  parameter int unsigned DEPTH   = c_DEPTH,
  parameter int unsigned CNT_W   = c_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RADDR_W-1:0]       i_id_rs1,
  input  logic [RADDR_W-1:0]       i_id_rs2,
  input  logic                     i_id_use_rs1,
  input  logic                     i_id_use_rs2,
  input  logic                     i_id_ex_memread,
  input  logic [RADDR_W-1:0]       i_id_ex_register_rd,
  input  logic                     i_ex_advance,
  input  logic                     i_mem_resp_valid,
  output logic                     o_lock,
  output logic                     o_ex_hold,
  output logic [$clog2(DEPTH):0]   o_busy_cnt,
  output logic [CNT_W-1:0]         o_stall_cycles,
  output logic                     o_underflow_err
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [RADDR_W-1:0] c_ZERO = RADDR_W'(c_REG_ZERO);

  logic [DEPTH-1:0][RADDR_W-1:0] w_entry_rd;
  logic [DEPTH-1:0]              w_entry_valid;
  logic [PTR_W-1:0]              w_head;
  logic [PTR_W:0]                w_count;
  logic                          w_ex_load;
  logic                          w_full;
  logic                          w_empty;
  logic                          w_push;
  logic                          w_pop;
  logic                          w_use1;
  logic                          w_use2;
  logic                          w_ex_match;
  logic                          w_pend1;
  logic                          w_pend2;
  logic [CNT_W-1:0]              r_stall_cycles;
  logic                          r_underflow_err;

  assign w_ex_load  = i_id_ex_memread && (i_id_ex_register_rd != c_ZERO);
  assign w_full     = (w_count == (PTR_W+1)'(DEPTH));
  assign w_empty    = (w_count == '0);
  assign o_ex_hold  = w_ex_load && w_full && !i_mem_resp_valid;
  assign w_push     = w_ex_load && i_ex_advance && !o_ex_hold;
  assign w_pop      = i_mem_resp_valid && !w_empty;

  assign w_use1     = i_id_use_rs1 && (i_id_rs1 != c_ZERO);
  assign w_use2     = i_id_use_rs2 && (i_id_rs2 != c_ZERO);
  assign w_ex_match = w_ex_load &&
                      ((w_use1 && (i_id_ex_register_rd == i_id_rs1)) ||
                       (w_use2 && (i_id_ex_register_rd == i_id_rs2)));

  // The head entry being returned this cycle is forwarded from MEM/WB.
  always_comb begin
    w_pend1 = 1'b0;
    w_pend2 = 1'b0;
    for (int e = 0; e < int'(DEPTH); e++) begin
      if (w_entry_valid[e] && !(i_mem_resp_valid && (w_head == PTR_W'(e)))) begin
        if (w_entry_rd[e] == i_id_rs1) w_pend1 = 1'b1;
        if (w_entry_rd[e] == i_id_rs2) w_pend2 = 1'b1;
      end
    end
  end

  assign o_lock = w_ex_match || (w_use1 && w_pend1) || (w_use2 && w_pend2) || o_ex_hold;

  fb_rd_fifo #(
    .RADDR_W (RADDR_W),
    .DEPTH   (DEPTH)
  ) u_rd_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wr_rd (i_id_ex_register_rd),
    .o_rd    (w_entry_rd),
    .o_valid (w_entry_valid),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles  <= '0;
      r_underflow_err <= 1'b0;
    end else begin
      if (o_lock && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (i_mem_resp_valid && w_empty) begin
        r_underflow_err <= 1'b1;
      end
    end
  end

  assign o_busy_cnt      = w_count;
  assign o_stall_cycles  = r_stall_cycles;
  assign o_underflow_err = r_underflow_err;
endmodule
`default_nettype wire

// File: tb/tb_fb_load_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_load_scoreboard
// Brief    : Directed bench with a queue-based reference model and per-cycle
//            compare, plus hand-computed literal checks.
// Revision : 1.0
// ============================================================================
module tb_fb_load_scoreboard;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int SAT   = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, exrd = '0;
  logic       u1 = 0, u2 = 0, mr = 0, adv = 0, resp = 0;
  logic       lock, hold, uf;
  logic [2:0] busy;
  logic [3:0] stall;

  int n_cmp = 0;
  int n_bad = 0;

  fb_load_scoreboard #(.RADDR_W(5), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_id_rs1            (rs1),
    .i_id_rs2            (rs2),
    .i_id_use_rs1        (u1),
    .i_id_use_rs2        (u2),
    .i_id_ex_memread     (mr),
    .i_id_ex_register_rd (exrd),
    .i_ex_advance        (adv),
    .i_mem_resp_valid    (resp),
    .o_lock              (lock),
    .o_ex_hold           (hold),
    .o_busy_cnt          (busy),
    .o_stall_cycles      (stall),
    .o_underflow_err     (uf)
  );

  always #5 clk = ~clk;

  // Reference model: outstanding loads as a plain queue, oldest first.
  int q[$];
  int m_stall = 0;
  bit m_uf    = 0;

  function automatic bit f_ex_load();
    return mr && (exrd != 0);
  endfunction

  function automatic bit f_hold();
    return f_ex_load() && (q.size() == DEPTH) && !resp;
  endfunction

  function automatic bit f_pend(int s);
    for (int i = (resp ? 1 : 0); i < q.size(); i++)
      if (q[i] == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit f_lock();
    bit s1 = u1 && (rs1 != 0);
    bit s2 = u2 && (rs2 != 0);
    bit exm = f_ex_load() && ((s1 && exrd == rs1) || (s2 && exrd == rs2));
    return exm || (s1 && f_pend(int'(rs1))) || (s2 && f_pend(int'(rs2))) || f_hold();
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_stall <= 0;
      m_uf    <= 1'b0;
    end else begin
      automatic bit do_push = f_ex_load() && adv && !f_hold();
      if (f_lock() && m_stall != SAT) m_stall <= m_stall + 1;
      if (resp) begin
        if (q.size() > 0) void'(q.pop_front());
        else m_uf <= 1'b1;
      end
      if (do_push) q.push_back(int'(exrd));
    end
  end

  task automatic check(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("model_lock",  int'(lock),  int'(f_lock()));
      check("model_hold",  int'(hold),  int'(f_hold()));
      check("model_busy",  int'(busy),  q.size());
      check("model_stall", int'(stall), m_stall);
      check("model_uf",    int'(uf),    int'(m_uf));
    end
  end

  task automatic apply(input logic [4:0] a_rs1, input logic a_u1,
                       input logic [4:0] a_rs2, input logic a_u2,
                       input logic a_mr, input logic [4:0] a_rd,
                       input logic a_adv, input logic a_resp);
    rs1 = a_rs1; u1 = a_u1; rs2 = a_rs2; u2 = a_u2;
    mr = a_mr; exrd = a_rd; adv = a_adv; resp = a_resp;
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    check("rst_busy",  int'(busy),  0);
    check("rst_stall", int'(stall), 0);
    check("rst_uf",    int'(uf),    0);
    check("rst_lock",  int'(lock),  0);
    check("rst_hold",  int'(hold),  0);
    #9 rst = 1'b0;
    go();

    // Classic EX-stage load-use
    apply(1, 1, 0, 0, 1, 1, 0, 0); #1;
    check("ldu_lock", int'(lock), 1);
    apply(2, 1, 3, 1, 1, 1, 0, 0); #1;
    check("ldu_nolock", int'(lock), 0);
    idle(); go();

    // x0 and unused source
    apply(0, 1, 0, 0, 1, 0, 0, 0); #1;
    check("x0_lock", int'(lock), 0);
    apply(0, 0, 0, 0, 1, 5, 1, 0); go();
    apply(0, 0, 5, 0, 0, 0, 0, 0); #1;
    check("unused_lock", int'(lock), 0);
    check("unused_busy", int'(busy), 1);
    do_reset(); go();

    // Multi-cycle load
    apply(0, 0, 0, 0, 1, 7, 1, 0); go();
    apply(7, 1, 0, 0, 0, 0, 0, 0); #1;
    check("mc_lock", int'(lock), 1);
    go(); go(); go();
    check("mc_stall", int'(stall), 3);
    apply(7, 1, 0, 0, 0, 0, 0, 1); #1;
    check("mc_resp_lock", int'(lock), 0);
    go();
    check("mc_busy", int'(busy), 0);
    idle(); do_reset(); go();

    // Full FIFO with same-cycle pop
    for (int i = 1; i <= 4; i++) begin
      apply(0, 0, 0, 0, 1, 5'(i), 1, 0); go();
    end
    check("full_busy", int'(busy), 4);
    apply(0, 0, 0, 0, 1, 9, 1, 0); #1;
    check("full_hold", int'(hold), 1);
    check("full_lock", int'(lock), 1);
    go();
    check("full_nopush", int'(busy), 4);
    apply(0, 0, 0, 0, 1, 9, 1, 1); #1;
    check("full_pop_hold", int'(hold), 0);
    go();
    check("full_pp_busy", int'(busy), 4);
    apply(2, 1, 0, 0, 0, 0, 0, 0); #1;
    check("head2_lock", int'(lock), 1);
    apply(2, 1, 0, 0, 0, 0, 0, 1); #1;
    check("head2_fwd", int'(lock), 0);
    apply(0, 0, 9, 1, 0, 0, 0, 0); #1;
    check("tail9_lock", int'(lock), 1);
    idle(); do_reset(); go();

    // Duplicate destination
    apply(0, 0, 0, 0, 1, 6, 1, 0); go(); go();
    apply(0, 0, 0, 0, 0, 0, 0, 1); go();
    apply(6, 1, 0, 0, 0, 0, 0, 0); #1;
    check("dup_lock", int'(lock), 1);
    apply(6, 1, 0, 0, 0, 0, 0, 1); #1;
    check("dup_last", int'(lock), 0);
    go();
    check("dup_busy", int'(busy), 0);

    // Underflow, sticky
    apply(0, 0, 0, 0, 0, 0, 0, 1); go();
    check("uf_set", int'(uf), 1);
    idle(); go(); go();
    check("uf_sticky", int'(uf), 1);

    // Reset mid-stream with three entries
    apply(0, 0, 0, 0, 1, 3, 1, 0); go();
    apply(3, 1, 0, 0, 1, 4, 1, 0); go();
    apply(3, 1, 0, 0, 1, 5, 1, 0); go();
    check("mid_busy", int'(busy), 3);
    idle(); #1;
    rst = 1'b1; #1;
    check("arst_busy",  int'(busy),  0);
    check("arst_stall", int'(stall), 0);
    check("arst_uf",    int'(uf),    0);
    check("arst_lock",  int'(lock),  0);
    rst = 1'b0;
    go();

    // Stall counter saturation
    apply(0, 0, 0, 0, 1, 10, 1, 0); go();
    apply(10, 1, 0, 0, 0, 0, 0, 0);
    repeat (20) go();
    check("sat_stall", int'(stall), SAT);
    check("sat_lock",  int'(lock),  1);
    idle(); go();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fb_load_scoreboard.md
Name: fb_load_scoreboard

Overview:
- Next-generation data-hazard unit for the Firebird pipeline, generalised for a multi-cycle, in-order data memory.
- Detects the classic EX-stage load-use hazard.
- Also tracks up to DEPTH loads still in flight past EX in an in-order destination FIFO, and locks the ID stage while any source depends on one of them.
- Sits beside the ID/EX pipeline registers. It drives the PC/IF-ID hold and the ID/EX bubble insert, and counts stall cycles for performance analysis.

Parameters:
- RADDR_W, 5, register address width.
- DEPTH, 4, maximum outstanding loads past EX (FIFO entries, power of two, ≥2).
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  asynchronous, active-high reset.
- id_rs1  input  RADDR_W  ID-stage source 1.
- id_rs2  input  RADDR_W  ID-stage source 2.
- id_use_rs1  input  1  instruction reads rs1.
- id_use_rs2  input  1  instruction reads rs2.
- id_ex_memread  input  1  EX-stage instruction is a load.
- id_ex_register_rd  input  RADDR_W  EX-stage destination.
- ex_advance  input  1  EX instruction moves to MEM this cycle.
- mem_resp_valid  input  1  oldest outstanding load returns data this cycle.
- lock  output  1  hold PC/IF-ID, bubble ID/EX (combinational).
- ex_hold  output  1  EX load cannot issue, FIFO full (combinational).
- busy_cnt  output  clog2(DEPTH)+1  valid FIFO entries.
- stall_cycles  output  CNT_W  saturating count of cycles with lock=1.
- underflow_err  output  1  sticky: response with empty FIFO.

Behaviour:
- Reset (async, rst=1): FIFO pointers=0, all entry valid bits=0, busy_cnt=0, stall_cycles=0, underflow_err=0. lock and ex_hold evaluate to 0 with FIFO empty and no EX load.
- Register x0 never causes a hazard. Sources with use=0 are ignored.
- ex_load = id_ex_memread && id_ex_register_rd!=0.
- Push: ex_load && ex_advance && !ex_hold. Writes id_ex_register_rd at the tail; the entry becomes visible next cycle.
- Pop: mem_resp_valid && busy_cnt!=0. Retires the head entry at the clock edge.
- Pop with busy_cnt==0: no state change; underflow_err set to 1, held until reset.
- ex_hold = ex_load && (busy_cnt==DEPTH) && !mem_resp_valid. When the FIFO is full, a same-cycle pop frees a slot, so push and pop both occur and busy_cnt stays at DEPTH.
- Simultaneous push and pop at any fill level: busy_cnt unchanged, pointers both advance modulo DEPTH.
- Pending match for source s: some valid entry e has rd[e]==s, excluding the head entry when mem_resp_valid=1. The returning load is forwarded from MEM/WB, so it causes no hazard.
- ex_match: ex_load && id_ex_register_rd equals a used nonzero source.
- lock = ex_match || pending match(rs1 && use_rs1) || pending match(rs2 && use_rs2) || ex_hold.
- Duplicate rd in the FIFO: the match is an OR over entries, so the hazard persists until the last matching entry retires.
- stall_cycles increments by 1 at each edge where lock=1 and saturates at all-ones.
- Latency: lock and ex_hold are same-cycle combinational. FIFO state updates one edge later.
- rst asserted mid-operation clears all in-flight tracking immediately. Software/pipeline flush is expected to accompany it.

Decomposition:
- Shared package fb_defines: RADDR_W, DEPTH default, register-zero constant.
- One sub-module, fb_rd_fifo: circular buffer with per-entry valid, exposing all entries plus head index for the parallel compare.
- Top level holds compare, lock logic and counters.

Test Plan:
- Classic load-use: EX load rd=1, ID rs1=1 use=1 → lock=1 same cycle. With ID rs1=2, rs2=3 → lock=0.
- x0 and unused source: EX load rd=0, ID rs1=0 → lock=0. FIFO holds rd=5, ID rs2=5 with use_rs2=0 → lock=0.
- Multi-cycle load: push rd=7, hold mem_resp_valid=0 for 3 cycles with ID rs1=7 → lock=1 for 3 cycles and stall_cycles=3. In the cycle mem_resp_valid=1 → lock=0, then busy_cnt=0.
- Full FIFO: push 4 loads (rd 1–4), then EX load rd=9 → ex_hold=1, lock=1. Same-cycle mem_resp_valid=1 → push accepted, busy_cnt stays 4, head now rd=2.
- Duplicate rd: push rd=6 twice, pop once, ID rs1=6 → lock=1. Pop again → lock=0.
- Underflow and reset: mem_resp_valid=1 with FIFO empty → underflow_err=1, sticky. Assert rst mid-stream with 3 entries → busy_cnt=0, stall_cycles=0, underflow_err=0 without waiting for a clock edge.
